// File: rtl/dpb_pkg.sv
// Shared types and widths for the JPEG-to-DPB packet writer.
// A descriptor announces one closed packet to the port-B reader.
package dpb_pkg;

  localparam int DPB_ADDR_W = 11;
  localparam int DPB_DATA_W = 128;
  localparam int BUF_RANK_W = 4;

  typedef struct packed {
    logic [BUF_RANK_W-1:0] buf_rank;
    logic [7:0]            udp_rank;
    logic [6:0]            cnt128;
    logic [5:0]            bytecnt;
    logic                  last;
  } dpb_desc_t;

endpackage

// File: rtl/dpb_desc_fifo.sv
// Small synchronous descriptor FIFO with occupancy count and
// a zeroed head while empty, so downstream fields read 0 when idle.
module dpb_desc_fifo
  import dpb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  dpb_desc_t                din,
  input  logic                     pop,
  output dpb_desc_t                head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  dpb_desc_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dpb_jpeg_pack_wr.sv
// Packs the MJPEG byte stream into 128-bit DPB words, fills a ring of
// packet buffers and queues one descriptor per closed packet for port B.
module dpb_jpeg_pack_wr
  import dpb_pkg::*;
#(
  parameter int PKT_WORDS = 64,
  parameter int NUM_BUF   = 16
) (
  input  logic                  i_pclk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_jpeg_data,
  input  logic                  i_jpeg_valid,
  input  logic                  i_jpeg_eof,
  output logic                  o_jpeg_ready,
  output logic                  o_dpb_a_clk,
  output logic                  o_dpb_a_cea,
  output logic                  o_dpb_a_ocea,
  output logic                  o_dpb_a_rst_n,
  output logic                  o_dpb_a_wr_en,
  output logic [DPB_ADDR_W-1:0] o_dpb_a_addr,
  output logic [DPB_DATA_W-1:0] o_dpb_a_wr_data,
  output logic                  o_wr_req,
  output logic [BUF_RANK_W-1:0] o_wr_buf_rank,
  output logic [7:0]            o_wr_udp_rank,
  output logic [6:0]            o_wr_buf_128cnt,
  output logic [5:0]            o_wr_buf_Bytecnt,
  output logic                  o_wr_frame_down,
  input  logic                  i_wr_down,
  output logic [15:0]           o_ovf_cnt
);

  localparam int CNT_W = $clog2(NUM_BUF) + 1;

  logic [3:0]            byte_idx;
  logic [6:0]            word_idx;
  logic [BUF_RANK_W-1:0] wr_rank;
  logic [7:0]            udp_rank;
  logic [CNT_W-1:0]      occ;
  logic [CNT_W-1:0]      occ_next;
  logic [DPB_DATA_W-1:0] word_reg;
  logic [DPB_DATA_W-1:0] word_fill;
  logic [6:0]            byte_lsb;
  logic                  ready_reg;
  logic                  accept;
  logic                  word_close;
  logic                  pkt_close;
  logic                  pop;
  logic                  push_reg;
  dpb_desc_t             desc_reg;
  dpb_desc_t             desc_next;
  dpb_desc_t             head;
  logic [CNT_W-1:0]      fifo_count;

  assign o_dpb_a_clk   = i_pclk;
  assign o_dpb_a_cea   = 1'b1;
  assign o_dpb_a_ocea  = 1'b1;
  assign o_dpb_a_rst_n = ~i_rst_n;
  assign o_jpeg_ready  = ready_reg;

  assign accept     = i_jpeg_valid && ready_reg;
  assign word_close = accept && (i_jpeg_eof || byte_idx == 4'd15);
  assign pkt_close  = word_close && (i_jpeg_eof || word_idx == 7'(PKT_WORDS - 1));
  assign pop        = i_wr_down && (fifo_count != '0);
  assign occ_next   = occ + CNT_W'(pkt_close) - CNT_W'(pop);

  // First byte of a word sits in the top byte lane.
  assign byte_lsb = 7'd120 - {byte_idx, 3'b000};

  always_comb begin
    word_fill = word_reg;
    word_fill[byte_lsb +: 8] = i_jpeg_data;
  end

  always_comb begin
    desc_next          = '0;
    desc_next.buf_rank = wr_rank;
    desc_next.udp_rank = udp_rank;
    if (i_jpeg_eof) begin
      desc_next.cnt128  = word_idx + 7'd1;
      desc_next.bytecnt = {2'b00, byte_idx} + 6'd1;
      desc_next.last    = 1'b1;
    end else begin
      desc_next.cnt128  = 7'(PKT_WORDS);
    end
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_idx        <= '0;
      word_idx        <= '0;
      wr_rank         <= '0;
      udp_rank        <= '0;
      occ             <= '0;
      word_reg        <= '0;
      ready_reg       <= 1'b0;
      push_reg        <= 1'b0;
      desc_reg        <= '0;
      o_dpb_a_wr_en   <= 1'b0;
      o_dpb_a_addr    <= '0;
      o_dpb_a_wr_data <= '0;
      o_ovf_cnt       <= '0;
    end else begin
      occ           <= occ_next;
      ready_reg     <= (occ_next < CNT_W'(NUM_BUF - 1));
      o_dpb_a_wr_en <= word_close;
      push_reg      <= pkt_close;
      if (accept) begin
        if (word_close) begin
          word_reg <= '0;
          byte_idx <= '0;
        end else begin
          word_reg <= word_fill;
          byte_idx <= byte_idx + 4'd1;
        end
      end
      if (word_close) begin
        o_dpb_a_addr    <= {wr_rank, word_idx};
        o_dpb_a_wr_data <= word_fill;
        word_idx        <= word_idx + 7'd1;
      end
      // Descriptor is held one cycle so the word write lands before req rises.
      if (pkt_close) begin
        desc_reg <= desc_next;
        word_idx <= '0;
        wr_rank  <= wr_rank + 1'b1;
        udp_rank <= i_jpeg_eof ? 8'd0 : udp_rank + 8'd1;
      end
      if (i_jpeg_valid && !ready_reg && o_ovf_cnt != 16'hFFFF)
        o_ovf_cnt <= o_ovf_cnt + 16'd1;
    end
  end

  dpb_desc_fifo #(
    .DEPTH (NUM_BUF)
  ) u_desc_fifo (
    .clk   (i_pclk),
    .rst_n (i_rst_n),
    .push  (push_reg),
    .din   (desc_reg),
    .pop   (i_wr_down),
    .head  (head),
    .count (fifo_count)
  );

  assign o_wr_req         = (fifo_count != '0);
  assign o_wr_buf_rank    = head.buf_rank;
  assign o_wr_udp_rank    = head.udp_rank;
  assign o_wr_buf_128cnt  = head.cnt128;
  assign o_wr_buf_Bytecnt = head.bytecnt;
  assign o_wr_frame_down  = head.last;

endmodule

// File: tb/tb_dpb_jpeg_pack_wr.sv
// Directed bench for the DPB packet writer: packing, descriptors,
// backpressure, coincident close/pop and asynchronous reset.
module tb_dpb_jpeg_pack_wr;

  logic         i_pclk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [7:0]   i_jpeg_data = '0;
  logic         i_jpeg_valid = 1'b0;
  logic         i_jpeg_eof = 1'b0;
  logic         o_jpeg_ready;
  logic         o_dpb_a_clk;
  logic         o_dpb_a_cea;
  logic         o_dpb_a_ocea;
  logic         o_dpb_a_rst_n;
  logic         o_dpb_a_wr_en;
  logic [10:0]  o_dpb_a_addr;
  logic [127:0] o_dpb_a_wr_data;
  logic         o_wr_req;
  logic [3:0]   o_wr_buf_rank;
  logic [7:0]   o_wr_udp_rank;
  logic [6:0]   o_wr_buf_128cnt;
  logic [5:0]   o_wr_buf_Bytecnt;
  logic         o_wr_frame_down;
  logic         i_wr_down = 1'b0;
  logic [15:0]  o_ovf_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int byte_ctr = 0;
  logic [10:0]  wq_addr[$];
  logic [127:0] wq_data[$];

  always #5 i_pclk = ~i_pclk;

  dpb_jpeg_pack_wr #(.PKT_WORDS(64), .NUM_BUF(16)) dut (
    .i_pclk           (i_pclk),
    .i_rst_n          (i_rst_n),
    .i_jpeg_data      (i_jpeg_data),
    .i_jpeg_valid     (i_jpeg_valid),
    .i_jpeg_eof       (i_jpeg_eof),
    .o_jpeg_ready     (o_jpeg_ready),
    .o_dpb_a_clk      (o_dpb_a_clk),
    .o_dpb_a_cea      (o_dpb_a_cea),
    .o_dpb_a_ocea     (o_dpb_a_ocea),
    .o_dpb_a_rst_n    (o_dpb_a_rst_n),
    .o_dpb_a_wr_en    (o_dpb_a_wr_en),
    .o_dpb_a_addr     (o_dpb_a_addr),
    .o_dpb_a_wr_data  (o_dpb_a_wr_data),
    .o_wr_req         (o_wr_req),
    .o_wr_buf_rank    (o_wr_buf_rank),
    .o_wr_udp_rank    (o_wr_udp_rank),
    .o_wr_buf_128cnt  (o_wr_buf_128cnt),
    .o_wr_buf_Bytecnt (o_wr_buf_Bytecnt),
    .o_wr_frame_down  (o_wr_frame_down),
    .i_wr_down        (i_wr_down),
    .o_ovf_cnt        (o_ovf_cnt)
  );

  // Capture every word write, away from the active edge.
  always @(negedge i_pclk) begin
    if (o_dpb_a_wr_en) begin
      wq_addr.push_back(o_dpb_a_addr);
      wq_data.push_back(o_dpb_a_wr_data);
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_desc(input string tag, input int rank, input int udp,
                            input int cnt, input int bc, input int last);
    check({tag, ".req"},  128'(o_wr_req), 128'd1);
    check({tag, ".rank"}, 128'(o_wr_buf_rank), 128'(rank));
    check({tag, ".udp"},  128'(o_wr_udp_rank), 128'(udp));
    check({tag, ".cnt"},  128'(o_wr_buf_128cnt), 128'(cnt));
    check({tag, ".bc"},   128'(o_wr_buf_Bytecnt), 128'(bc));
    check({tag, ".last"}, 128'(o_wr_frame_down), 128'(last));
    $display("desc %s: rank=%0d udp=%0d cnt=%0d bc=%0d last=%0d", tag,
             o_wr_buf_rank, o_wr_udp_rank, o_wr_buf_128cnt, o_wr_buf_Bytecnt, o_wr_frame_down);
  endtask

  task automatic apply_reset();
    @(negedge i_pclk);
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_pclk);
    i_rst_n = 1'b1;
    @(negedge i_pclk);
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic pulse_down();
    i_wr_down = 1'b1;
    @(negedge i_pclk);
    i_wr_down = 1'b0;
  endtask

  // Send n bytes (value = running byte_ctr); optional eof and down on the last byte.
  task automatic send_bytes(input int n, input bit eof_last, input bit down_last);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (!o_jpeg_ready && t < 200) begin
        i_jpeg_valid = 1'b0;
        @(negedge i_pclk);
        t++;
      end
      if (!o_jpeg_ready) begin
        check("ready_timeout", 128'(o_jpeg_ready), 128'd1);
        break;
      end
      i_jpeg_data  = 8'(byte_ctr);
      byte_ctr++;
      i_jpeg_valid = 1'b1;
      i_jpeg_eof   = eof_last && (i == n - 1);
      i_wr_down    = down_last && (i == n - 1);
      @(negedge i_pclk);
    end
    i_jpeg_valid = 1'b0;
    i_jpeg_eof   = 1'b0;
    i_wr_down    = 1'b0;
  endtask

  initial begin
    int accepted;
    // Reset state while reset is held
    repeat (2) @(negedge i_pclk);
    check("rst.wr_en", 128'(o_dpb_a_wr_en), 128'd0);
    check("rst.addr",  128'(o_dpb_a_addr), 128'd0);
    check("rst.data",  o_dpb_a_wr_data, 128'd0);
    check("rst.req",   128'(o_wr_req), 128'd0);
    check("rst.cnt",   128'(o_wr_buf_128cnt), 128'd0);
    check("rst.ovf",   128'(o_ovf_cnt), 128'd0);
    check("rst.ready", 128'(o_jpeg_ready), 128'd0);
    check("rst.cea",   128'(o_dpb_a_cea), 128'd1);
    check("rst.ocea",  128'(o_dpb_a_ocea), 128'd1);
    check("rst.arst",  128'(o_dpb_a_rst_n), 128'd1);
    i_rst_n = 1'b1;
    @(negedge i_pclk);
    check("ready_after_rst", 128'(o_jpeg_ready), 128'd1);

    // 1024-byte frame: one final packet of 64 full words
    byte_ctr = 0;
    send_bytes(1024, 1'b1, 1'b0);
    repeat (2) @(negedge i_pclk);
    check("f1k.nwr", 128'(wq_addr.size()), 128'd64);
    if (wq_addr.size() == 64) begin
      check("f1k.addr0",  128'(wq_addr[0]), 128'h000);
      check("f1k.addr63", 128'(wq_addr[63]), 128'h03F);
      check("f1k.data0",  wq_data[0], 128'h000102030405060708090A0B0C0D0E0F);
      check("f1k.data63", wq_data[63], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    end
    check_desc("f1k", 0, 0, 64, 16, 1);
    pulse_down();
    check("f1k.req_pop", 128'(o_wr_req), 128'd0);
    pulse_down();
    check("empty_down.ready", 128'(o_jpeg_ready), 128'd1);
    check("empty_down.req",   128'(o_wr_req), 128'd0);

    // 1500-byte frame: one full packet plus a 30-word tail with 12 bytes in the last word
    apply_reset();
    byte_ctr = 0;
    send_bytes(1500, 1'b1, 1'b0);
    repeat (2) @(negedge i_pclk);
    check("f1500.nwr", 128'(wq_addr.size()), 128'd94);
    if (wq_addr.size() == 94) begin
      check("f1500.addr64", 128'(wq_addr[64]), 128'h080);
      check("f1500.addrL",  128'(wq_addr[93]), 128'h09D);
      check("f1500.dataL",  wq_data[93], 128'hD0D1D2D3D4D5D6D7D8D9DADB00000000);
    end
    check_desc("f1500.p0", 0, 0, 64, 0, 0);
    pulse_down();
    check_desc("f1500.p1", 1, 1, 30, 12, 1);
    pulse_down();
    check("f1500.req_pop", 128'(o_wr_req), 128'd0);

    // Single-byte frame lands in the next buffer with udp_rank restarted
    wq_addr.delete();
    wq_data.delete();
    i_jpeg_data = 8'hAB;
    byte_ctr = 8'hAB;
    send_bytes(1, 1'b1, 1'b0);
    repeat (2) @(negedge i_pclk);
    check("f1.nwr", 128'(wq_addr.size()), 128'd1);
    if (wq_addr.size() == 1) begin
      check("f1.addr", 128'(wq_addr[0]), 128'h100);
      check("f1.data", wq_data[0], 128'hAB << 120);
    end
    check_desc("f1", 2, 0, 1, 1, 1);
    pulse_down();

    // Continuous stream with no reader: ready drops after 15 packets
    apply_reset();
    accepted = 0;
    for (int c = 0; c < 15400; c++) begin
      i_jpeg_valid = 1'b1;
      i_jpeg_eof   = 1'b0;
      i_jpeg_data  = 8'(c);
      if (o_jpeg_ready) accepted++;
      @(negedge i_pclk);
    end
    i_jpeg_valid = 1'b0;
    $display("stream: accepted=%0d ovf=%0d ready=%0d", accepted, o_ovf_cnt, o_jpeg_ready);
    check("bp.accepted", 128'(accepted), 128'd15360);
    check("bp.ready",    128'(o_jpeg_ready), 128'd0);
    check("bp.ovf",      128'(o_ovf_cnt), 128'd40);
    check_desc("bp.head", 0, 0, 64, 0, 0);
    pulse_down();
    check("bp.ready_back", 128'(o_jpeg_ready), 128'd1);
    check_desc("bp.head1", 1, 1, 64, 0, 0);

    // Packet close coincident with a pop: occupancy holds, order preserved
    send_bytes(1024, 1'b0, 1'b1);
    repeat (2) @(negedge i_pclk);
    check("coin.ready", 128'(o_jpeg_ready), 128'd1);
    for (int k = 2; k <= 15; k++) begin
      check("coin.req",  128'(o_wr_req), 128'd1);
      check("coin.rank", 128'(o_wr_buf_rank), 128'(k));
      check("coin.udp",  128'(o_wr_udp_rank), 128'(k));
      pulse_down();
    end
    check("coin.req_end", 128'(o_wr_req), 128'd0);

    // Asynchronous reset mid-word clears everything without a clock edge
    send_bytes(5, 1'b0, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst.addr",  128'(o_dpb_a_addr), 128'd0);
    check("arst.data",  o_dpb_a_wr_data, 128'd0);
    check("arst.ovf",   128'(o_ovf_cnt), 128'd0);
    check("arst.ready", 128'(o_jpeg_ready), 128'd0);
    check("arst.req",   128'(o_wr_req), 128'd0);
    check("arst.rstn",  128'(o_dpb_a_rst_n), 128'd1);
    @(negedge i_pclk);
    i_rst_n = 1'b1;
    @(negedge i_pclk);
    wq_addr.delete();
    wq_data.delete();
    byte_ctr = 0;
    send_bytes(20, 1'b1, 1'b0);
    repeat (2) @(negedge i_pclk);
    check("post.nwr", 128'(wq_addr.size()), 128'd2);
    if (wq_addr.size() == 2) begin
      check("post.addr0", 128'(wq_addr[0]), 128'h000);
      check("post.data1", wq_data[1], 128'h10111213000000000000000000000000);
    end
    check_desc("post", 0, 0, 2, 4, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dpb_jpeg_pack_wr.md
# dpb_jpeg_pack_wr

Write-side master for the 2048×128 packet dual-port buffer (DPB) port A. It accepts the MJPEG encoder byte stream and packs 16 bytes into each 128-bit word. Words go into a ring of 16 packet buffers of up to 127 words each. Every closed packet is announced to the port-B reader (UDP 128-bit sender side) through a level req / pulse done handshake carrying buffer rank, packet rank, word count and tail byte count.

## Interface
- PKT_WORDS, 64: words per non-final packet; legal 1..127.
- NUM_BUF, 16: packet buffers in ring; fixed by 4-bit rank.
- i_pclk  in  1  clock; all logic, DPB port A clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_jpeg_data  in  8  stream byte.
- i_jpeg_valid  in  1  byte present; accepted when o_jpeg_ready=1.
- i_jpeg_eof  in  1  qualifies the accepted byte as last byte of frame.
- o_jpeg_ready  out  1  free buffer available.
- o_dpb_a_clk  out  1  = i_pclk.
- o_dpb_a_cea / o_dpb_a_ocea  out  1  constant 1.
- o_dpb_a_rst_n  out  1  = ~i_rst_n.
- o_dpb_a_wr_en  out  1  word write strobe.
- o_dpb_a_addr  out  11  {buf_rank[3:0], word_idx[6:0]}.
- o_dpb_a_wr_data  out  128  packed word.
- o_wr_req  out  1  descriptor pending; level.
- o_wr_buf_rank  out  4  buffer holding packet.
- o_wr_udp_rank  out  8  packet index within frame.
- o_wr_buf_128cnt  out  7  words written.
- o_wr_buf_Bytecnt  out  6  valid bytes in last word (final packet, 1..16); 0 otherwise.
- o_wr_frame_down  out  1  packet is last of frame.
- i_wr_down  in  1  one-cycle pulse: reader finished head descriptor.
- o_ovf_cnt  out  16  bytes offered (valid) while ready=0; saturating.

## Operation
- Packing: byte_idx 0..15. Byte k lands in bits [127-8k -: 8]; first byte MSB. Unfilled bytes are zero.
- Word close: a word closes on the 16th byte or on an eof byte. The closed word is written to {wr_rank, word_idx}, then word_idx increments.
- Packet close, non-final: word_idx reaches PKT_WORDS with no eof. Descriptor is {wr_rank, udp_rank, PKT_WORDS, 0, 0}. udp_rank increments.
- Packet close, final: an eof byte closes it. Descriptor is {wr_rank, udp_rank, word_idx+1, byte_idx+1, 1}. udp_rank is cleared to 0.
- After any packet close: wr_rank increments mod 16, word_idx is cleared to 0, occ increments.
- Reader-side length check: (128cnt−1)·16+Bytecnt gives the final packet length; 128cnt·16 gives a full packet length.
- Descriptor FIFO, depth NUM_BUF. Head fields drive the o_wr_* outputs. o_wr_req = ~empty.
- On i_wr_down with FIFO non-empty: pop the head and decrement occ. With FIFO empty, i_wr_down is ignored.
- o_jpeg_ready = (occ < NUM_BUF−1). The buffer being filled never aliases an unread buffer.
- udp_rank wraps at 256 without error.

## Timing
- Reset value of every output is 0, except the constants and o_dpb_a_clk. All ranks, indices, occ and the FIFO are cleared.
- Reset mid-packet discards the partial word and all pending descriptors.
- Write latency: o_dpb_a_wr_en pulses exactly 1 cycle after the closing byte is accepted, with addr and data registered. Packing continues with no stall, so full-rate input is supported.
- Descriptor push latency: 2 cycles after the closing byte. The word write is therefore complete before o_wr_req can rise.
- o_wr_* fields are stable while o_wr_req=1. The next descriptor appears the cycle after a pop.
- Packet close and i_wr_down in the same cycle: occ unchanged. FIFO push and pop in the same cycle are both honoured.
- occ increments in the close-byte cycle, so o_jpeg_ready falls the next cycle. At most one byte is accepted past the threshold. The threshold leaves that margin.

## Structure
- Package dpb_pkg:
  - dpb_desc_t struct {buf_rank[3:0], udp_rank[7:0], cnt128[6:0], bytecnt[5:0], last}.
  - Constants DPB_ADDR_W=11, DPB_DATA_W=128, BUF_RANK_W=4.
- Sub-module dpb_desc_fifo: synchronous FIFO of dpb_desc_t, depth NUM_BUF, with count output.
- Top level: byte packer, rank/index counters, occ counter.

## Test plan
- 1024-byte frame, eof on last byte, PKT_WORDS=64 -> 64 writes at addr 0x000–0x03F and one descriptor {0,0,64,16,1}.
- 1500-byte frame -> descriptors {0,0,64,0,0} and {1,1,30,12,1}. 2nd packet's last word is addr 0x09D with bytes 12..15 zero.
- Single-byte frame 0xAB -> wr_data = 0xAB<<120 and descriptor {rank,0,1,1,1}.
- No i_wr_down, continuous stream -> ready falls after 15 packets closed, o_ovf_cnt counts. One i_wr_down restores ready next cycle.
- i_wr_down coincident with packet close -> occ unchanged and FIFO order preserved. i_wr_down on an empty FIFO is ignored.
- i_rst_n asserted mid-word -> all outputs 0 asynchronously. Next frame starts at addr 0x000 with udp_rank 0.
